// File: rtl/lmem_hd_unloader.sv
// lmem_hd_unloader
//   Drives the Lmem unload port after decoding, captures the returned
//   hard-decision vectors and streams the systematic bits out as a
//   circulant-major sequence of HDWIDTH-bit words over valid/ready.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle launch pulse, honoured only when idle
//   busy, done          unload in progress / one-cycle completion pulse
//   unload_en           Lmem unload read strobe (one per issued read)
//   unloadAddress       Lmem unload address (0..WPC-1), held between reads
//   unload_HDout_vec    Lmem hard-decision vector, circulant c at [c*HDWIDTH +: HDWIDTH]
//   hd_data, hd_index   output word and its index c*WPC + a
//   hd_valid, hd_ready  output handshake
//   hd_last             marks word index Kb*WPC-1
module lmem_hd_unloader #(
  parameter int Kb           = 14,
  parameter int Z            = 511,
  parameter int HDWIDTH      = 32,
  parameter int ADDRESSWIDTH = 5,
  parameter int WPC          = 16,
  parameter int RD_LAT       = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      unload_en,
  output logic [ADDRESSWIDTH-1:0]   unloadAddress,
  input  logic [Kb*HDWIDTH-1:0]     unload_HDout_vec,
  output logic [HDWIDTH-1:0]        hd_data,
  output logic [7:0]                hd_index,
  output logic                      hd_valid,
  input  logic                      hd_ready,
  output logic                      hd_last
);

  localparam int CW       = $clog2(Kb);
  localparam int AW       = $clog2(WPC);
  localparam int PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW       = $clog2(FIFO_DEPTH + 1);
  localparam int PAD_BITS = Z - HDWIDTH * (WPC - 1);
  localparam int LAST_IDX = Kb * WPC - 1;
  // Valid bits of the final (partial) word of each circulant.
  localparam logic [HDWIDTH-1:0] LAST_MASK = HDWIDTH'((64'd1 << PAD_BITS) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic [CW-1:0]       r_c;
  logic [AW-1:0]       r_a;

  // Read-side pipeline: tags each issued read until its data returns.
  logic                r_pv [RD_LAT];
  logic [CW-1:0]       r_pc [RD_LAT];
  logic [AW-1:0]       r_pa [RD_LAT];

  logic [HDWIDTH-1:0]  r_fd [FIFO_DEPTH];
  logic [7:0]          r_fi [FIFO_DEPTH];
  logic [PW-1:0]       r_wp, r_rp;
  logic [NW-1:0]       r_cnt;

  logic                w_pop, w_push, w_issue, w_last_rd;
  logic [7:0]          w_inflight;
  logic [HDWIDTH-1:0]  w_word;
  logic [7:0]          w_index;

  always_comb begin
    w_inflight = '0;
    for (int unsigned k = 0; k < RD_LAT; k++) w_inflight = w_inflight + 8'(r_pv[k]);
    w_pop     = (r_cnt != '0) && hd_ready;
    // Credit: FIFO entries plus reads still in flight, less this cycle's pop.
    w_issue   = (r_state == S_RUN) &&
                ((8'(r_cnt) + w_inflight - 8'(w_pop)) < 8'(FIFO_DEPTH));
    w_last_rd = (r_c == CW'(Kb - 1)) && (r_a == AW'(WPC - 1));
    w_push    = r_pv[RD_LAT-1];
    w_word    = unload_HDout_vec[int'(r_pc[RD_LAT-1]) * HDWIDTH +: HDWIDTH];
    if (r_pa[RD_LAT-1] == AW'(WPC - 1)) w_word = w_word & LAST_MASK;
    w_index   = 8'(int'(r_pc[RD_LAT-1]) * WPC + int'(r_pa[RD_LAT-1]));
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_issue && w_last_rd) w_state_next = S_DRAIN;
      S_DRAIN: if (w_pop && hd_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_c   <= '0;
      r_a   <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int unsigned k = 0; k < RD_LAT; k++) r_pv[k] <= 1'b0;
    end else begin
      // Counters freeze on the final read so the address holds its last value.
      if (r_state == S_IDLE && start) begin
        r_c <= '0;
        r_a <= '0;
      end else if (w_issue && !w_last_rd) begin
        if (r_a == AW'(WPC - 1)) begin
          r_a <= '0;
          r_c <= r_c + 1'b1;
        end else begin
          r_a <= r_a + 1'b1;
        end
      end
      r_pv[0] <= w_issue;
      for (int unsigned k = 1; k < RD_LAT; k++) r_pv[k] <= r_pv[k-1];
      if (w_push) r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
      r_cnt <= r_cnt + NW'(w_push) - NW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    r_pc[0] <= r_c;
    r_pa[0] <= r_a;
    for (int unsigned k = 1; k < RD_LAT; k++) begin
      r_pc[k] <= r_pc[k-1];
      r_pa[k] <= r_pa[k-1];
    end
    if (w_push) begin
      r_fd[r_wp] <= w_word;
      r_fi[r_wp] <= w_index;
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign unload_en     = w_issue;
  assign unloadAddress = ADDRESSWIDTH'(r_a);
  assign hd_valid      = (r_cnt != '0);
  assign hd_data       = hd_valid ? r_fd[r_rp] : '0;
  assign hd_index      = hd_valid ? r_fi[r_rp] : '0;
  assign hd_last       = hd_valid && (r_fi[r_rp] == 8'(LAST_IDX));

endmodule

// File: tb/tb_lmem_hd_unloader.sv
module tb_lmem_hd_unloader;
  localparam int KB = 14, WPC = 16, NWORDS = 224, DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, hd_ready;
  logic               busy, done, unload_en, hd_valid, hd_last;
  logic [4:0]         unloadAddress;
  logic [KB*32-1:0]   vec;
  logic [31:0]        hd_data;
  logic [7:0]         hd_index;

  lmem_hd_unloader #(.Kb(14), .Z(511), .HDWIDTH(32), .ADDRESSWIDTH(5),
                     .WPC(16), .RD_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .unload_en(unload_en), .unloadAddress(unloadAddress),
    .unload_HDout_vec(vec), .hd_data(hd_data), .hd_index(hd_index),
    .hd_valid(hd_valid), .hd_ready(hd_ready), .hd_last(hd_last));

  // Lmem model: content table, two-cycle read latency.
  logic [31:0] tab [KB][WPC];
  logic [3:0]  p1_a, p2_a;
  always @(posedge clk) begin
    p1_a <= unloadAddress[3:0];
    p2_a <= p1_a;
  end
  always_comb begin
    vec = '0;
    for (int c = 0; c < KB; c++) vec[c*32 +: 32] = tab[c][p2_a];
  end

  int errors = 0, checks = 0;

  // Observations of one run.
  int          q_idx[$];
  logic [31:0] q_dat[$];
  logic        q_last[$];
  int          q_cyc[$];
  int done_cyc, done_cnt, first_valid, max_out, stab_bad, addr_bad, en_stall;
  logic post_rst_or, busy_at_done, busy_after, timeout;
  int bad_at;
  logic [31:0] bad_got, bad_want;

  task automatic fill_tab(input int mode);
    for (int c = 0; c < KB; c++)
      for (int a = 0; a < WPC; a++)
        case (mode)
          0:       tab[c][a] = {4'(c), 4'(a), 24'h5A5A5A};
          1:       tab[c][a] = 32'hFFFF_FFFF;
          default: tab[c][a] = $urandom;
        endcase
  endtask

  // Word (c,a) carries codeword bits c*511 + 32a + j; for a=15 only j<31 exist.
  function automatic logic [31:0] ref_word(input int i);
    logic [31:0] w;
    w = tab[i / WPC][i % WPC];
    if (i % WPC == WPC - 1) w[31] = 1'b0;
    return w;
  endfunction

  function automatic int seq_bad();
    int n = 0;
    bad_at = -1;
    for (int i = 0; i < q_idx.size(); i++)
      if (q_idx[i] != i || q_dat[i] !== ref_word(i) || q_last[i] !== (i == NWORDS - 1)) begin
        if (n == 0) begin bad_at = i; bad_got = q_dat[i]; bad_want = ref_word(i); end
        n++;
      end
    return n;
  endfunction

  // Runs one unload from a start pulse, recording what the consumer sees.
  task automatic run_stream(input int pct, input int stall_after, input int rst_idx,
                            input bit spam, input int budget);
    int issued = 0, xfer = 0, stall_left = 0, rst_phase = 0, post_cnt = 0;
    bit prev_hold = 0, stop = 0, in_stall;
    logic [31:0] pd = '0;
    logic [7:0]  pi = '0;
    logic        pl = 1'b0;
    q_idx.delete(); q_dat.delete(); q_last.delete(); q_cyc.delete();
    done_cyc = -1; done_cnt = 0; first_valid = -1; max_out = 0;
    stab_bad = 0; addr_bad = 0; en_stall = 0;
    post_rst_or = 1'b1; busy_at_done = 1'b0; busy_after = 1'b1; timeout = 1'b0;
    @(negedge clk); rst = 1'b0; start = 1'b1; hd_ready = 1'b1;
    for (int cyc = 1; cyc <= budget && !stop; cyc++) begin
      @(negedge clk);
      rst = (rst_phase == 1);
      in_stall = (stall_left > 0);
      if (in_stall) begin hd_ready = 1'b0; stall_left--; end
      else hd_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      start = (spam && done_cyc < 0 && rst_phase == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (rst) begin rst_phase = 2; prev_hold = 0; continue; end
      if (rst_phase == 2) begin
        post_rst_or = |{busy, done, unload_en, unloadAddress, hd_valid, hd_data, hd_index, hd_last};
        rst_phase = 3;
      end
      if (rst_phase == 3) begin post_cnt++; if (post_cnt >= 20) stop = 1; end
      if (prev_hold && !(hd_valid && hd_data === pd && hd_index === pi && hd_last === pl))
        stab_bad++;
      if (unload_en) begin
        if (unloadAddress !== 5'(issued % WPC)) addr_bad++;
        issued++;
        if (in_stall) en_stall++;
      end
      if (hd_valid && first_valid < 0) first_valid = cyc;
      if (hd_valid && hd_ready && rst_phase == 0) begin
        q_idx.push_back(int'(hd_index)); q_dat.push_back(hd_data);
        q_last.push_back(hd_last); q_cyc.push_back(cyc);
        xfer++;
        if (stall_after >= 0 && xfer == stall_after + 1) stall_left = 50;
        if (rst_idx >= 0 && int'(hd_index) == rst_idx) rst_phase = 1;
      end
      if (issued - xfer > max_out) max_out = issued - xfer;
      prev_hold = hd_valid && !hd_ready;
      pd = hd_data; pi = hd_index; pl = hd_last;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin busy_after = busy; stop = 1; end
    end
    if (!stop) timeout = 1'b1;
    start = 1'b0; hd_ready = 1'b1; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; hd_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, unload_en, unloadAddress, hd_valid, hd_data, hd_index, hd_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b en=%b addr=%0d valid=%b data=%h idx=%0d last=%b, want all 0",
               busy, done, unload_en, unloadAddress, hd_valid, hd_data, hd_index, hd_last);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || unload_en !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b en=%b want 0 0", busy, unload_en);
    end
  endtask

  task automatic test_full_stream();
    int n;
    fill_tab(0);
    run_stream(100, -1, -1, 1'b0, 400);
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL full_timeout: no done within budget"); end
    checks++; if (q_idx.size() != NWORDS) begin errors++; $display("FAIL full_count: got %0d want %0d", q_idx.size(), NWORDS); end
    n = seq_bad();
    checks++; if (n !== 0) begin errors++; $display("FAIL full_seq: %0d bad, first %0d got %h want %h", n, bad_at, bad_got, bad_want); end
    checks++; if (first_valid !== 4) begin errors++; $display("FAIL full_first_valid: got %0d want 4", first_valid); end
    checks++; if (q_cyc.size() == NWORDS && q_cyc[NWORDS-1] !== 227) begin errors++; $display("FAIL full_last_cycle: got %0d want 227", q_cyc[NWORDS-1]); end
    checks++; if (done_cyc !== 228) begin errors++; $display("FAIL full_done_cycle: got %0d want 228", done_cyc); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_pulse: got %0d pulses want 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin errors++; $display("FAIL full_busy: at done %b after %b want 1 0", busy_at_done, busy_after); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL full_addr_order: got %0d bad want 0", addr_bad); end
    checks++; if (q_dat.size() > 47 && q_dat[47] !== 32'h2F5A5A5A) begin errors++; $display("FAIL word_c2_a15: got %h want 2f5a5a5a", q_dat[47]); end
    checks++; if (q_dat.size() > 143 && q_dat[143] !== 32'h0F5A5A5A) begin errors++; $display("FAIL word_c8_a15: got %h want 0f5a5a5a", q_dat[143]); end
  endtask

  task automatic test_random_ready();
    int n;
    fill_tab(2);
    run_stream(50, -1, -1, 1'b0, 2000);
    n = seq_bad();
    checks++; if (timeout !== 1'b0 || q_idx.size() != NWORDS) begin errors++; $display("FAIL rand_count: got %0d words timeout=%b want %0d", q_idx.size(), timeout, NWORDS); end
    checks++; if (n !== 0) begin errors++; $display("FAIL rand_seq: %0d bad, first %0d got %h want %h", n, bad_at, bad_got, bad_want); end
    checks++; if (stab_bad !== 0) begin errors++; $display("FAIL rand_stall_stable: got %0d changes want 0", stab_bad); end
    checks++; if (max_out > DEPTH) begin errors++; $display("FAIL rand_credit: outstanding %0d want <= %0d", max_out, DEPTH); end
    checks++; if (done_cnt !== 1 || addr_bad !== 0) begin errors++; $display("FAIL rand_done_addr: done=%0d addr_bad=%0d want 1 0", done_cnt, addr_bad); end
  endtask

  task automatic test_stall();
    int n;
    fill_tab(0);
    run_stream(100, 10, -1, 1'b0, 600);
    n = seq_bad();
    checks++; if (timeout !== 1'b0 || q_idx.size() != NWORDS) begin errors++; $display("FAIL stall_count: got %0d words timeout=%b want %0d", q_idx.size(), timeout, NWORDS); end
    checks++; if (n !== 0) begin errors++; $display("FAIL stall_seq: %0d bad, first %0d got %h want %h", n, bad_at, bad_got, bad_want); end
    checks++; if (en_stall > DEPTH) begin errors++; $display("FAIL stall_issues: got %0d reads during stall want <= %0d", en_stall, DEPTH); end
    checks++; if (q_cyc.size() > 11 && q_cyc[11] !== 65) begin errors++; $display("FAIL stall_resume: word 11 at %0d want 65", q_cyc[11]); end
    checks++; if (done_cyc !== 278) begin errors++; $display("FAIL stall_done_cycle: got %0d want 278", done_cyc); end
    checks++; if (stab_bad !== 0 || max_out > DEPTH) begin errors++; $display("FAIL stall_hold: changes=%0d outstanding=%0d want 0 <=4", stab_bad, max_out); end
  endtask

  task automatic test_reset_mid();
    int n;
    fill_tab(2);
    run_stream(100, -1, 100, 1'b0, 400);
    checks++; if (post_rst_or !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got nonzero=%b want 0", post_rst_or); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt); end
    checks++; if (q_idx.size() != 101) begin errors++; $display("FAIL midrst_words: got %0d want 101", q_idx.size()); end
    run_stream(100, -1, -1, 1'b0, 400);
    n = seq_bad();
    checks++; if (q_idx.size() != NWORDS || n !== 0) begin errors++; $display("FAIL midrst_restart: %0d words %0d bad, first %0d got %h want %h", q_idx.size(), n, bad_at, bad_got, bad_want); end
    checks++; if (done_cyc !== 228) begin errors++; $display("FAIL midrst_done_cycle: got %0d want 228", done_cyc); end
  endtask

  task automatic test_start_ignored();
    int n;
    fill_tab(0);
    @(negedge clk); rst = 1'b1; start = 1'b1;
    @(negedge clk); rst = 1'b0; start = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || unload_en !== 1'b0) begin errors++; $display("FAIL start_with_rst: busy=%b en=%b want 0 0", busy, unload_en); end
    run_stream(100, -1, -1, 1'b1, 400);
    n = seq_bad();
    checks++; if (q_idx.size() != NWORDS || n !== 0) begin errors++; $display("FAIL spam_seq: %0d words %0d bad, first %0d got %h want %h", q_idx.size(), n, bad_at, bad_got, bad_want); end
    checks++; if (done_cyc !== 228 || done_cnt !== 1) begin errors++; $display("FAIL spam_done: cycle %0d pulses %0d want 228 1", done_cyc, done_cnt); end
  endtask

  task automatic test_all_ones();
    int n;
    fill_tab(1);
    run_stream(75, -1, -1, 1'b0, 1000);
    n = seq_bad();
    checks++; if (q_idx.size() != NWORDS || n !== 0) begin errors++; $display("FAIL ones_seq: %0d words %0d bad, first %0d got %h want %h", q_idx.size(), n, bad_at, bad_got, bad_want); end
    checks++; if (q_dat.size() > 15 && q_dat[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_full_word: got %h want ffffffff", q_dat[0]); end
    checks++; if (q_dat.size() > 15 && q_dat[15] !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ones_pad_word: got %h want 7fffffff", q_dat[15]); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hd_ready = 1'b0;
    fill_tab(0);
    test_reset();
    test_full_stream();
    test_random_ready();
    test_stall();
    test_reset_mid();
    test_start_ignored();
    test_all_ones();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lmem_hd_unloader.md
# lmem_hd_unloader

Hard-decision unload sequencer that sits directly downstream of the bit node memory (Lmem). After decoding finishes, it drives the Lmem unload port (`unload_en`, `unloadAddress`) and captures the returned `Kb*HDWIDTH`-bit hard-decision vectors. It re-orders the systematic bits into a circulant-major stream of 32-bit words and delivers them over a valid/ready handshake to the output interface. It replaces the bench-level peeking at `unload_HDout_vec_regout`.

## Interface
Parameters:
- `Kb`, 14, systematic circulant columns
- `Z`, 511, circulant size
- `HDWIDTH`, 32, hard-decision bits per circulant per unload address
- `ADDRESSWIDTH`, 5, Lmem unload address width
- `WPC`, 16, words per circulant = ceil(Z/HDWIDTH)
- `RD_LAT`, 2, cycles from `unload_en` to valid `unload_HDout_vec`
- `FIFO_DEPTH`, 4, output buffer entries; must be ≥ RD_LAT+2

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse from the controller; accepted only in IDLE
- `busy`  out  1  unload in progress
- `done`  out  1  one-cycle pulse after the last word is transferred
- `unload_en`  out  1  Lmem unload read strobe
- `unloadAddress`  out  ADDRESSWIDTH  Lmem unload address, 0..WPC-1
- `unload_HDout_vec`  in  Kb*HDWIDTH  Lmem hard-decision vector; circulant c occupies `[c*32 +: 32]`
- `hd_data`  out  32  output word
- `hd_index`  out  8  word index = c*WPC + a
- `hd_valid`  out  1  output word valid
- `hd_ready`  in  1  consumer ready
- `hd_last`  out  1  high with word index Kb*WPC-1 (223)

## Operation
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DRAIN once all 224 reads have been issued.
  - DRAIN → DONE when the word with `hd_last` transfers.
  - DONE → IDLE unconditionally after 1 cycle.
- Read order: the outer loop is circulant c = 0..Kb-1 and the inner loop is address a = 0..WPC-1. This gives 224 reads with one word selected per read. Counters c (4 bits) and a (4 bits) wrap a 15→0 and then increment c.
- Word select: c is delayed RD_LAT cycles alongside the read. The captured word is `unload_HDout_vec[c*32 +: 32]`.
- Bit j of word (c, a) is codeword bit c*Z + 32a + j.
- Padding: for a = WPC-1, bits at positions ≥ Z-32*(WPC-1) (= 31) are forced to 0.
- Credit rule: a read is issued in a cycle only if FIFO occupancy + in-flight reads − (pop this cycle) < FIFO_DEPTH. The FIFO never overflows.
- A word is transferred when `hd_valid` and `hd_ready` are both high. While `hd_valid` is high and `hd_ready` is low, `hd_data`, `hd_index` and `hd_last` are held stable.
- `start` is ignored while `busy` is high. If `start` and `rst` are asserted in the same cycle, `rst` wins.
- Reset, including mid-operation:
  - Next state is IDLE; FIFO and counters are cleared.
  - In-flight read data is discarded.
  - No `done` pulse is produced.
  - All outputs are 0 on the cycle after `rst` is sampled high.

## Timing
- Reset value of every output is 0.
- `start` sampled at cycle 0:
  - `busy`=1 from cycle 1.
  - First `unload_en` with address 0 at cycle 1.
  - First capture at cycle 1+RD_LAT.
  - First `hd_valid` at cycle 2+RD_LAT (= 4).
- With `hd_ready` held high, throughput is one word per cycle:
  - Last word is valid at cycle 227.
  - `done`=1 at cycle 228, with `busy` still 1 in that cycle.
  - `busy`=0 from cycle 229.
- `unload_en` is high only in cycles with an issued read. `unloadAddress` holds its last value otherwise.

## Test plan
- Lmem model returning word (c, a) = {c[3:0], a[3:0], 24'h5A5A5A} with `hd_ready`=1, `start` at cycle 0 → 224 words in index order 0..223, first at cycle 4, `hd_last` on index 223, `done` at cycle 228. The a=15 words have bit 31 cleared, e.g. c=2 reads 0x2F5A5A5A.
- Same stimulus with `hd_ready` random at 50% → identical word sequence with no loss or duplication. Outputs are stable during stalls, and occupancy + in-flight never exceeds 4.
- `hd_ready` dropped after word 10 for 50 cycles → `unload_en` stops within FIFO_DEPTH issues. After `hd_ready` returns, transfer resumes at word 11 and completes correctly.
- `rst` pulsed when `hd_index`=100 → all outputs 0 the next cycle and no `done`. A new `start` then yields the full sequence from index 0.
- `start` repeated while `busy`, and `start` together with `rst` → both ignored; the sequence and `done` timing are unchanged.
- All-ones HD vector → words with a≠15 read 0xFFFFFFFF and a=15 words read 0x7FFFFFFF.
